// File: rtl/drive_arbiter.sv
// Drive arbiter: estop/manual/line arbitration, per-wheel PWM, and dead-time sequencing on polarity reversal.
// Optional duty ramping is enabled by defining DRIVE_RAMP_EN. Encoding: direction 0 = FORWARDS, 1 = REVERSE.
module drive_arbiter #(
  parameter int PWM_PERIOD = 100,
  parameter int DUTY_FULL  = 100,
  parameter int DUTY_SLOW  = 40,
  parameter int DUTY_PIVOT = 60,
  parameter int DEADTIME   = 50000,
  parameter int RAMP_STEP  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       direction,
  input  logic [3:0] dir_cmd,
  input  logic       man_en,
  input  logic [3:0] man_cmd,
  input  logic       estop,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic [1:0] state,
  output logic [1:0] src
);

  localparam int DW = 9;
  localparam int TW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  localparam logic [DW-1:0] PERIOD_LAST = DW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] D_FULL      = DW'(DUTY_FULL);
  localparam logic [DW-1:0] D_SLOW      = DW'(DUTY_SLOW);
  localparam logic [DW-1:0] D_PIVOT     = DW'(DUTY_PIVOT);
  localparam logic [TW-1:0] DT_LAST     = TW'(DEADTIME - 1);

`ifdef DRIVE_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif
  // Without ramping the step limit exceeds any possible duty difference, so duty jumps to target.
  localparam logic [DW:0] STEP_LIM = (DW+1)'(RAMP_EN ? RAMP_STEP : 512);

  localparam logic       FORWARDS     = 1'b0;
  localparam logic [3:0] CMD_STOP     = 4'd0;
  localparam logic [3:0] CMD_PROCEED  = 4'd1;
  localparam logic [3:0] CMD_HARD_L   = 4'd2;
  localparam logic [3:0] CMD_HARD_R   = 4'd3;
  localparam logic [3:0] CMD_NINETY_L = 4'd4;
  localparam logic [3:0] CMD_NINETY_R = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DEAD  = 2'd2,
    S_ESTOP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] dt_q, dt_d;
  logic [DW-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic          dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic          pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic [1:0]    src_q, src_d;
  logic [DW-1:0] tgt_duty_l_q, tgt_duty_l_d, tgt_duty_r_q, tgt_duty_r_d;
  logic          tgt_pol_l_q, tgt_pol_l_d, tgt_pol_r_q, tgt_pol_r_d;
  logic          tgt_stop_q, tgt_stop_d;

  logic [3:0] sel_cmd;
  logic       fwd_l, fwd_r;
  logic       wrap, pol_diff;

  function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic [DW-1:0] step;
    step = STEP_LIM[DW-1:0];
    if (tgt > cur)
      step_toward = ({1'b0, tgt - cur} > STEP_LIM) ? cur + step : tgt;
    else
      step_toward = ({1'b0, cur - tgt} > STEP_LIM) ? cur - step : tgt;
  endfunction

  always_comb begin
    sel_cmd = dir_cmd;
    src_d   = 2'd0;
    if (estop) begin
      sel_cmd = CMD_STOP;
      src_d   = 2'd2;
    end else if (man_en) begin
      sel_cmd = man_cmd;
      src_d   = 2'd1;
    end
  end

  // STOP keeps the present wheel polarity so that stopping never triggers a dead-time.
  always_comb begin
    tgt_stop_d   = 1'b0;
    tgt_duty_l_d = '0;
    tgt_duty_r_d = '0;
    fwd_l        = 1'b1;
    fwd_r        = 1'b1;
    case (sel_cmd)
      CMD_PROCEED:  begin tgt_duty_l_d = D_FULL;  tgt_duty_r_d = D_FULL;  end
      CMD_HARD_L:   begin tgt_duty_l_d = D_SLOW;  tgt_duty_r_d = D_FULL;  end
      CMD_HARD_R:   begin tgt_duty_l_d = D_FULL;  tgt_duty_r_d = D_SLOW;  end
      CMD_NINETY_L: begin tgt_duty_l_d = D_PIVOT; tgt_duty_r_d = D_PIVOT; fwd_l = 1'b0; end
      CMD_NINETY_R: begin tgt_duty_l_d = D_PIVOT; tgt_duty_r_d = D_PIVOT; fwd_r = 1'b0; end
      default:      tgt_stop_d = 1'b1;
    endcase
    tgt_pol_l_d = tgt_stop_d ? dir_l_q : (fwd_l ^ (direction != FORWARDS));
    tgt_pol_r_d = tgt_stop_d ? dir_r_q : (fwd_r ^ (direction != FORWARDS));
  end

  assign wrap     = (cnt_q == PERIOD_LAST);
  assign pol_diff = (tgt_pol_l_q != dir_l_q) || (tgt_pol_r_q != dir_r_q);
  assign cnt_d    = wrap ? '0 : cnt_q + DW'(1);

  always_comb begin
    state_d  = state_q;
    dt_d     = dt_q;
    duty_l_d = duty_l_q;
    duty_r_d = duty_r_q;
    dir_l_d  = dir_l_q;
    dir_r_d  = dir_r_q;
    if (estop) begin
      state_d  = S_ESTOP;
      dt_d     = '0;
      duty_l_d = '0;
      duty_r_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wrap) begin
            duty_l_d = '0;
            duty_r_d = '0;
          end
          if (!tgt_stop_q) begin
            if (pol_diff) begin
              state_d  = S_DEAD;
              dt_d     = '0;
              duty_l_d = '0;
              duty_r_d = '0;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pol_diff) begin
            state_d  = S_DEAD;
            dt_d     = '0;
            duty_l_d = '0;
            duty_r_d = '0;
          end else if (tgt_stop_q) begin
            state_d = S_IDLE;
            if (wrap) begin
              duty_l_d = '0;
              duty_r_d = '0;
            end
          end else if (wrap) begin
            duty_l_d = step_toward(duty_l_q, tgt_duty_l_q);
            duty_r_d = step_toward(duty_r_q, tgt_duty_r_q);
          end
        end
        S_DEAD: begin
          duty_l_d = '0;
          duty_r_d = '0;
          // Polarity is taken from the target as it stands at the terminal count, not at entry.
          if (dt_q == DT_LAST) begin
            dt_d    = '0;
            dir_l_d = tgt_pol_l_q;
            dir_r_d = tgt_pol_r_q;
            state_d = tgt_stop_q ? S_IDLE : S_RUN;
          end else begin
            dt_d = dt_q + TW'(1);
          end
        end
        default: begin
          duty_l_d = '0;
          duty_r_d = '0;
          dt_d     = '0;
          state_d  = S_DEAD;
        end
      endcase
    end
  end

  // Output PWM is registered from next-state values, so duty zeroing shows on the same edge.
  assign pwm_l_d = (cnt_d < duty_l_d);
  assign pwm_r_d = (cnt_d < duty_r_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dt_q         <= '0;
      duty_l_q     <= '0;
      duty_r_q     <= '0;
      dir_l_q      <= 1'b1;
      dir_r_q      <= 1'b1;
      pwm_l_q      <= 1'b0;
      pwm_r_q      <= 1'b0;
      src_q        <= 2'd0;
      tgt_duty_l_q <= '0;
      tgt_duty_r_q <= '0;
      tgt_pol_l_q  <= 1'b1;
      tgt_pol_r_q  <= 1'b1;
      tgt_stop_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dt_q         <= dt_d;
      duty_l_q     <= duty_l_d;
      duty_r_q     <= duty_r_d;
      dir_l_q      <= dir_l_d;
      dir_r_q      <= dir_r_d;
      pwm_l_q      <= pwm_l_d;
      pwm_r_q      <= pwm_r_d;
      src_q        <= src_d;
      tgt_duty_l_q <= tgt_duty_l_d;
      tgt_duty_r_q <= tgt_duty_r_d;
      tgt_pol_l_q  <= tgt_pol_l_d;
      tgt_pol_r_q  <= tgt_pol_r_d;
      tgt_stop_q   <= tgt_stop_d;
    end
  end

  assign pwm_l = pwm_l_q;
  assign pwm_r = pwm_r_q;
  assign dir_l = dir_l_q;
  assign dir_r = dir_r_q;
  assign state = state_q;
  assign src   = src_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter: steady-state vector table plus hand-written estop, manual,
// ramp (with DRIVE_RAMP_EN) and mid-operation reset sequences.
module tb_drive_arbiter;

  localparam int PERIOD = 10;
  localparam int DT     = 20;

  localparam logic       FWD = 1'b0;
  localparam logic       REV = 1'b1;
  localparam logic [3:0] C_STOP = 4'd0, C_PROC = 4'd1, C_HL = 4'd2, C_HR = 4'd3, C_NL = 4'd4, C_NR = 4'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       direction;
  logic [3:0] dir_cmd;
  logic       man_en;
  logic [3:0] man_cmd;
  logic       estop;
  logic       pwm_l, pwm_r, dir_l, dir_r;
  logic [1:0] state, src;

  int testsRun = 0;
  int testsFailed = 0;

  drive_arbiter #(
    .PWM_PERIOD(10), .DUTY_FULL(10), .DUTY_SLOW(4), .DUTY_PIVOT(6), .DEADTIME(20), .RAMP_STEP(3)
  ) dut (
    .clk(clk), .rst(rst), .direction(direction), .dir_cmd(dir_cmd), .man_en(man_en),
    .man_cmd(man_cmd), .estop(estop), .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l),
    .dir_r(dir_r), .state(state), .src(src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dirn;
    logic [3:0] cmd;
    logic       men;
    logic [3:0] mcmd;
    logic       es;
    int         xsrc;
    int         xstate;
    int         xdl;
    int         xdr;
    int         xhl;
    int         xhr;
    int         xdt;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input int idx, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    direction = v.dirn;
    dir_cmd   = v.cmd;
    man_en    = v.men;
    man_cmd   = v.mcmd;
    estop     = v.es;
  endtask

  // Settle long enough for dead-time and ramping, then measure one full PWM period.
  task automatic runVector(input vec_t v, input int idx);
    int dtCycles, dtHigh, hl, hr;
    dtCycles = 0; dtHigh = 0; hl = 0; hr = 0;
    applyStimulus(v);
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (state == 2'd2) begin
        dtCycles++;
        if (pwm_l || pwm_r) dtHigh++;
      end
    end
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      hl += int'(pwm_l);
      hr += int'(pwm_r);
    end
    checkOutput("src", idx, int'(src), v.xsrc);
    checkOutput("state", idx, int'(state), v.xstate);
    checkOutput("dir_l", idx, int'(dir_l), v.xdl);
    checkOutput("dir_r", idx, int'(dir_r), v.xdr);
    checkOutput("high_l", idx, hl, v.xhl);
    checkOutput("high_r", idx, hr, v.xhr);
    checkOutput("deadtime_len", idx, dtCycles, v.xdt);
    checkOutput("deadtime_pwm", idx, dtHigh, 0);
  endtask

  task automatic countDeadtime(input string name, input int idx);
    int dtCycles, dtHigh;
    dtCycles = 0; dtHigh = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (state == 2'd2) begin
        dtCycles++;
        if (pwm_l || pwm_r) dtHigh++;
      end
    end
    checkOutput(name, idx, dtCycles, DT);
    checkOutput("deadtime_pwm", idx, dtHigh, 0);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{FWD, C_PROC, 1'b0, C_STOP, 1'b0, 0, 1, 1, 1, 10, 10, 0};
    vecs[1]  = '{FWD, C_HL,   1'b0, C_STOP, 1'b0, 0, 1, 1, 1,  4, 10, 0};
    vecs[2]  = '{FWD, C_HR,   1'b0, C_STOP, 1'b0, 0, 1, 1, 1, 10,  4, 0};
    vecs[3]  = '{FWD, C_NR,   1'b0, C_STOP, 1'b0, 0, 1, 1, 0,  6,  6, 20};
    vecs[4]  = '{FWD, C_NL,   1'b0, C_STOP, 1'b0, 0, 1, 0, 1,  6,  6, 20};
    vecs[5]  = '{FWD, C_STOP, 1'b0, C_STOP, 1'b0, 0, 0, 0, 1,  0,  0, 0};
    vecs[6]  = '{REV, C_PROC, 1'b0, C_STOP, 1'b0, 0, 1, 0, 0, 10, 10, 20};
    vecs[7]  = '{REV, C_PROC, 1'b1, C_HR,   1'b0, 1, 1, 0, 0, 10,  4, 0};
    vecs[8]  = '{REV, C_PROC, 1'b1, 4'd15,  1'b0, 1, 0, 0, 0,  0,  0, 0};
    vecs[9]  = '{FWD, C_NL,   1'b0, C_STOP, 1'b0, 0, 1, 0, 1,  6,  6, 20};
    vecs[10] = '{FWD, C_NL,   1'b0, C_STOP, 1'b1, 2, 3, 0, 1,  0,  0, 0};
    vecs[11] = '{FWD, C_PROC, 1'b0, C_STOP, 1'b0, 0, 1, 1, 1, 10, 10, 20};

    rst = 1'b0; direction = FWD; dir_cmd = C_STOP; man_en = 1'b0; man_cmd = C_STOP; estop = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_pwm_l", 0, int'(pwm_l), 0);
    checkOutput("reset_pwm_r", 0, int'(pwm_r), 0);
    checkOutput("reset_dir_l", 0, int'(dir_l), 1);
    checkOutput("reset_dir_r", 0, int'(dir_r), 1);
    checkOutput("reset_state", 0, int'(state), 0);
    checkOutput("reset_src", 0, int'(src), 0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) runVector(vecs[i], i);

    // Estop mid-period while running PROCEED, then full dead-time after release.
    repeat (3) @(negedge clk);
    checkOutput("pre_estop_pwm_l", 0, int'(pwm_l), 1);
    estop = 1'b1;
    @(posedge clk); #1;
    checkOutput("estop_pwm_l", 0, int'(pwm_l), 0);
    checkOutput("estop_pwm_r", 0, int'(pwm_r), 0);
    checkOutput("estop_state", 0, int'(state), 3);
    checkOutput("estop_src", 0, int'(src), 2);
    @(negedge clk);
    estop = 1'b0;
    countDeadtime("estop_release_dt", 0);
    seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      @(negedge clk);
      if (pwm_l && pwm_r) seen = 1;
    end
    checkOutput("estop_resume", 0, seen, 1);

    // Manual STOP override over line PROCEED, then drop back to line arbitration.
    @(negedge clk);
    man_en = 1'b1; man_cmd = C_STOP;
    @(posedge clk); #1;
    checkOutput("man_src", 0, int'(src), 1);
    @(posedge clk); #1;
    checkOutput("man_state", 0, int'(state), 0);
    repeat (15) @(negedge clk);
    checkOutput("man_pwm_l", 0, int'(pwm_l), 0);
    man_en = 1'b0;
    @(posedge clk); #1;
    checkOutput("line_src", 0, int'(src), 0);
    @(posedge clk); #1;
    checkOutput("line_state", 0, int'(state), 1);

`ifdef DRIVE_RAMP_EN
    // Ramp from IDLE: successive periods show duty 3, 6, 9, 10.
    @(negedge clk);
    dir_cmd = C_STOP;
    repeat (30) @(negedge clk);
    dir_cmd = C_PROC;
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clk);
      if (pwm_l) seen = 1;
    end
    checkOutput("ramp_start", 0, seen, 1);
    begin
      int win [4];
      int expRamp [4];
      expRamp[0] = 3; expRamp[1] = 6; expRamp[2] = 9; expRamp[3] = 10;
      for (int w = 0; w < 4; w++) win[w] = 0;
      for (int j = 0; j < 40; j++) begin
        if (j > 0) @(negedge clk);
        win[j / PERIOD] += int'(pwm_l);
      end
      for (int w = 0; w < 4; w++) checkOutput("ramp_period", w, win[w], expRamp[w]);
    end
`endif

    // Reset in the middle of a manual NINETY_RIGHT drive.
    @(negedge clk);
    man_en = 1'b1; man_cmd = C_NR;
    repeat (90) @(negedge clk);
    checkOutput("pre_reset_dir_r", 0, int'(dir_r), 0);
    checkOutput("pre_reset_src", 0, int'(src), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_state", 0, int'(state), 0);
    checkOutput("midreset_dir_r", 0, int'(dir_r), 1);
    checkOutput("midreset_src", 0, int'(src), 0);
    checkOutput("midreset_pwm_l", 0, int'(pwm_l), 0);
    checkOutput("midreset_pwm_r", 0, int'(pwm_r), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
